// File: rtl/kypd_scanner_if.sv
// Keypad scanner bus: matrix pins plus the debounced key outputs.
//   row_i        keypad rows, active-low, asynchronous to the clock
//   col_o        column drive, active-low, one-hot-low
//   key_value_o  last committed key code
//   key_valid_o  high while a debounced key is held
//   key_press_o  one-cycle pulse on a new key commit
// master: the scanner; slave: keypad + downstream consumer.
interface kypd_scanner_if;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_value_o;
  logic       key_valid_o;
  logic       key_press_o;

  modport master (
    input  row_i,
    output col_o,
    output key_value_o,
    output key_valid_o,
    output key_press_o
  );

  modport slave (
    output row_i,
    input  col_o,
    input  key_value_o,
    input  key_valid_o,
    input  key_press_o
  );
endinterface

// File: rtl/kypd_scanner.sv
// 4x4 keypad scanner with column rotation, priority decode and debounce.
//   clk_i  system clock
//   rst_i  asynchronous active-high reset
//   kp     kypd_scanner_if.master (rows in, columns and key outputs out)
module kypd_scanner #(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  kypd_scanner_if.master kp
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  // Key code indexed by {row, col}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  logic [3:0]    row_meta, row_sync;
  logic [1:0]    col_idx;
  logic [DW-1:0] dwell;

  logic          acc_found;
  logic [3:0]    acc_code;
  logic          prev_found;
  logic [3:0]    prev_code;
  logic [CW-1:0] match_cnt;

  logic          sample_c, scan_done_c, col_hit_c;
  logic [1:0]    col_row_c, col_next_c;
  logic [3:0]    col_code_c;
  logic          res_found_c;
  logic [3:0]    res_code_c;
  logic          match_c, commit_c;
  logic [CW-1:0] cnt_next_c;

  // Dwell end of a column is the sample point; column 3's is the scan end.
  assign sample_c    = (dwell == DW'(SETTLE_CYCLES - 1));
  assign scan_done_c = sample_c && (col_idx == 2'd3);
  assign col_next_c  = col_idx + 2'd1;
  assign col_hit_c   = ~&row_sync;

  // Lowest pressed row in the current column.
  always_comb begin
    col_row_c = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync[i]) col_row_c = 2'(i);
    end
  end

  assign col_code_c = KEY_MAP[{col_row_c, col_idx}];

  // Earlier columns win; NONE is carried as found=0 with code 0.
  assign res_found_c = acc_found | col_hit_c;
  assign res_code_c  = acc_found ? acc_code : (col_hit_c ? col_code_c : 4'h0);
  assign match_c     = ({res_found_c, res_code_c} == {prev_found, prev_code});

  always_comb begin
    cnt_next_c = CW'(1);
    if (match_c) begin
      cnt_next_c = (match_cnt == CW'(DEBOUNCE_SCANS)) ? match_cnt : match_cnt + CW'(1);
    end
  end

  // Commit only when the count reaches the threshold, not while saturated.
  assign commit_c = scan_done_c && (cnt_next_c == CW'(DEBOUNCE_SCANS)) &&
                    !(match_c && (match_cnt == CW'(DEBOUNCE_SCANS)));

  // Row synchronizer, dwell counter and column rotation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      col_idx  <= 2'd0;
      dwell    <= '0;
      kp.col_o <= 4'b1110;
    end else begin
      row_meta <= kp.row_i;
      row_sync <= row_meta;
      if (sample_c) begin
        dwell    <= '0;
        col_idx  <= col_next_c;
        kp.col_o <= ~(4'b0001 << col_next_c);
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Per-scan accumulator of the first pressed key.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_found <= 1'b0;
      acc_code  <= 4'h0;
    end else if (scan_done_c) begin
      acc_found <= 1'b0;
      acc_code  <= 4'h0;
    end else if (sample_c && !acc_found && col_hit_c) begin
      acc_found <= 1'b1;
      acc_code  <= col_code_c;
    end
  end

  // Debounce: count consecutive identical scan results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_found <= 1'b0;
      prev_code  <= 4'h0;
      match_cnt  <= '0;
    end else if (scan_done_c) begin
      if (!match_c) begin
        prev_found <= res_found_c;
        prev_code  <= res_code_c;
      end
      match_cnt <= cnt_next_c;
    end
  end

  // Committed key outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kp.key_value_o <= 4'h0;
      kp.key_valid_o <= 1'b0;
      kp.key_press_o <= 1'b0;
    end else begin
      kp.key_press_o <= 1'b0;
      if (commit_c) begin
        if (res_found_c) begin
          if (!kp.key_valid_o || (res_code_c != kp.key_value_o)) begin
            kp.key_value_o <= res_code_c;
            kp.key_valid_o <= 1'b1;
            kp.key_press_o <= 1'b1;
          end
        end else begin
          kp.key_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/kypd_scanner.md
KYPD_SCANNER -- requirements
Module: kypd_scanner

Interface
REQ-001 SETTLE_CYCLES, 1000, clock cycles each column is driven before its rows are sampled; legal range 4 to 65535.
REQ-002 DEBOUNCE_SCANS, 4, consecutive identical full-scan results required before a result is committed; legal range 1 to 15.
REQ-003 clk_i  input  1  system clock; the only clock.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 row_i  input  4  keypad row pins, active-low, externally pulled up, asynchronous to clk_i.
REQ-006 col_o  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 key_value_o  output  4  last committed key code; feeds the downstream key-to-divider decoder directly.
REQ-008 key_valid_o  output  1  high while a debounced key is held.
REQ-009 key_press_o  output  1  one-cycle pulse when a new key is committed.

Function
REQ-010 row_i SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value only.
REQ-011 Column index SHALL run 0,1,2,3,0,...; col_o = ~(4'b0001 << col_idx).
REQ-012 Dwell counter SHALL count 0 to SETTLE_CYCLES-1 per column.
REQ-013 At dwell == SETTLE_CYCLES-1, the block SHALL sample the synchronized rows for the current column, then advance col_idx and clear the counter on the next edge.
REQ-014 One full scan SHALL take exactly 4*SETTLE_CYCLES cycles; scan-complete SHALL be the column-3 sample cycle.
REQ-015 Key map (row r, column c), active row bit = 0: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D.
REQ-016 Scan result SHALL be the first pressed key in priority order: lowest column, then lowest row; no pressed key = NONE.
REQ-017 Debounce at scan-complete: if result equals previous result, the match counter SHALL increment, saturating at DEBOUNCE_SCANS; otherwise the previous result SHALL be replaced and the counter set to 1.
REQ-018 Commit SHALL occur on the edge after the scan-complete cycle in which the counter first equals DEBOUNCE_SCANS.
REQ-019 On commit of a key K when key_valid_o=0, or K differs from key_value_o: key_value_o<=K, key_valid_o<=1, key_press_o=1 for exactly one cycle.
REQ-020 On commit of a key equal to the held key_value_o while key_valid_o=1: no output change and no pulse.
REQ-021 On commit of NONE: key_valid_o<=0; key_value_o SHALL hold its last value; no pulse.
REQ-022 A direct key-to-key change without an intervening NONE SHALL produce a new press pulse after debounce.
REQ-023 Changes on row_i between sample points SHALL have no effect.

Reset
REQ-024 While rst_i=1: col_idx=0, col_o=4'b1110, dwell=0, synchronizer flops=4'hF, previous result=NONE, match count=0.
REQ-025 While rst_i=1: key_value_o=4'h0, key_valid_o=0, key_press_o=0.
REQ-026 Reset asserted mid-scan or mid-debounce SHALL discard all partial state; scanning SHALL restart at column 0 on the first edge after release.

Verification (SETTLE_CYCLES=8, DEBOUNCE_SCANS=3)
REQ-027 Idle after reset, row_i=4'hF -> col_o rotates 1110,1101,1011,0111 with 8 cycles per column; key_valid_o=0; no pulse ever.
REQ-028 Hold key 5 (row1 low whenever col1 is driven) from reset -> after exactly 3 complete scans: key_value_o=4'h5, key_valid_o=1, one single-cycle key_press_o; release for 3 scans -> key_valid_o=0, key_value_o stays 4'h5.
REQ-029 Key 9 bounces (present in scans 1 and 3, absent in 2, 4 and 5) -> no commit and no pulse; then held stable 3 scans -> commit 4'h9.
REQ-030 Keys 2 and 4 held simultaneously -> commit 4'h4 (column 0 beats column 1).
REQ-031 Key A held, then changed directly to D -> two press pulses, values 4'hA then 4'hD, key_valid_o never drops.
REQ-032 rst_i pulsed during the 2nd debounce scan of key 7 -> outputs return to reset values; commit of 4'h7 only after 3 full scans counted from reset release.
